// File: rtl/rv_plic_claim_ctrl.sv
// PLIC target slice: per-source gateways (idle/pending/active), priority selection and claim/complete handling.
// Define PLIC_SRC_SYNC_EN to put a 2-flop synchronizer on intr_src_i (source-to-irq latency becomes 4 cycles).
module rv_plic_claim_ctrl #(
    parameter int NumSrc = 32,
    parameter int PrioW = 3,
    localparam int SrcW = $clog2(NumSrc + 1)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumSrc-1:0]       intr_src_i,
    input  logic [NumSrc-1:0]       le_i,
    input  logic [NumSrc*PrioW-1:0] prio_i,
    input  logic [NumSrc-1:0]       ie_i,
    input  logic [PrioW-1:0]        threshold_i,
    input  logic                    claim_re_i,
    input  logic                    complete_we_i,
    input  logic [SrcW-1:0]         complete_id_i,
    output logic [SrcW-1:0]         claim_id_o,
    output logic                    irq_o,
    output logic [SrcW-1:0]         irq_id_o,
    output logic [NumSrc-1:0]       ip_o
);

    typedef enum logic [1:0] {
        GW_IDLE   = 2'd0,
        GW_PEND   = 2'd1,
        GW_ACTIVE = 2'd2
    } gw_state_e;

    logic [NumSrc-1:0] src;
    logic [NumSrc-1:0] pend_vec;
    logic [NumSrc-1:0] claim_vec;
    logic [SrcW-1:0]   irq_id_reg;
    logic [SrcW-1:0]   irq_id_next;
    logic              irq_reg;
    logic [SrcW-1:0]   claim_id_reg;
    logic [PrioW-1:0]  sel_prio;

`ifdef PLIC_SRC_SYNC_EN
    logic [NumSrc-1:0] sync1_reg;
    logic [NumSrc-1:0] sync2_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= intr_src_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign src = sync2_reg;
`else
    assign src = intr_src_i;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NumSrc; gi++) begin : g_gw
            localparam logic [SrcW-1:0] gw_id = SrcW'(gi + 1);

            gw_state_e state_reg;
            logic      prev_reg;
            logic      sticky_reg;
            logic      edge_hit;
            logic      claim_hit;
            logic      compl_hit;
            logic      retrig;

            assign edge_hit  = src[gi] & ~prev_reg;
            assign claim_hit = claim_re_i & (irq_id_reg == gw_id) & (state_reg == GW_PEND);
            assign compl_hit = complete_we_i & (complete_id_i == gw_id) & (state_reg == GW_ACTIVE);
            // An edge coinciding with the complete is treated as arriving after it.
            assign retrig    = le_i[gi] ? (sticky_reg | edge_hit) : src[gi];

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state_reg  <= GW_IDLE;
                    prev_reg   <= 1'b0;
                    sticky_reg <= 1'b0;
                end else begin
                    prev_reg <= src[gi];
                    case (state_reg)
                        GW_IDLE: begin
                            if (le_i[gi] ? edge_hit : src[gi]) begin
                                state_reg <= GW_PEND;
                            end
                        end
                        GW_PEND: begin
                            if (claim_hit) begin
                                state_reg <= GW_ACTIVE;
                            end
                        end
                        GW_ACTIVE: begin
                            if (compl_hit) begin
                                state_reg  <= retrig ? GW_PEND : GW_IDLE;
                                sticky_reg <= 1'b0;
                            end else if (le_i[gi] && edge_hit) begin
                                sticky_reg <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= GW_IDLE;
                        end
                    endcase
                end
            end

            assign pend_vec[gi]  = (state_reg == GW_PEND);
            assign claim_vec[gi] = claim_hit;
        end
    endgenerate

    // Strict compare on priority keeps the lowest ID on ties; the source being claimed is excluded.
    always_comb begin
        irq_id_next = '0;
        sel_prio    = '0;
        for (int i = 0; i < NumSrc; i++) begin
            if (pend_vec[i] && ie_i[i] && !claim_vec[i] &&
                (prio_i[i*PrioW +: PrioW] > threshold_i) &&
                (prio_i[i*PrioW +: PrioW] > sel_prio)) begin
                sel_prio    = prio_i[i*PrioW +: PrioW];
                irq_id_next = SrcW'(i + 1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_id_reg   <= '0;
            irq_reg      <= 1'b0;
            claim_id_reg <= '0;
        end else begin
            irq_id_reg <= irq_id_next;
            irq_reg    <= (irq_id_next != '0);
            if (claim_re_i) begin
                claim_id_reg <= irq_id_reg;
            end
        end
    end

    assign claim_id_o = claim_id_reg;
    assign irq_o      = irq_reg;
    assign irq_id_o   = irq_id_reg;
    assign ip_o       = pend_vec;

endmodule

// File: tb/tb_rv_plic_claim_ctrl.sv
// Bench for rv_plic_claim_ctrl: directed vector table, hand sequences, then random traffic against a reference model.
module tb_rv_plic_claim_ctrl;
    localparam int NumSrc = 32;
    localparam int PrioW = 3;
    localparam int SrcW = $clog2(NumSrc + 1);
    localparam logic [NumSrc-1:0] ALL = 32'hFFFF_FFFF;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [NumSrc-1:0]       intr_src = '0;
    logic [NumSrc-1:0]       le = '0;
    logic [NumSrc*PrioW-1:0] prio = '0;
    logic [NumSrc-1:0]       ie = '0;
    logic [PrioW-1:0]        thr = '0;
    logic                    claim_re = 1'b0;
    logic                    complete_we = 1'b0;
    logic [SrcW-1:0]         complete_id = '0;
    logic [SrcW-1:0]         claim_id;
    logic                    irq;
    logic [SrcW-1:0]         irq_id;
    logic [NumSrc-1:0]       ip;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_plic_claim_ctrl #(.NumSrc(NumSrc), .PrioW(PrioW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .intr_src_i   (intr_src),
        .le_i         (le),
        .prio_i       (prio),
        .ie_i         (ie),
        .threshold_i  (thr),
        .claim_re_i   (claim_re),
        .complete_we_i(complete_we),
        .complete_id_i(complete_id),
        .claim_id_o   (claim_id),
        .irq_o        (irq),
        .irq_id_o     (irq_id),
        .ip_o         (ip)
    );

    // Reference model: each source is a small life-cycle record; selection scans priority levels top-down.
    typedef enum int {M_IDLE, M_PEND, M_ACT} mstate_e;
    mstate_e m_st[NumSrc];
    bit      m_sticky[NumSrc];
    bit      m_prev[NumSrc];
    int      m_irq_id;
    int      m_claim_id;

    function automatic void model_reset();
        for (int i = 0; i < NumSrc; i++) begin
            m_st[i] = M_IDLE;
            m_sticky[i] = 1'b0;
            m_prev[i] = 1'b0;
        end
        m_irq_id = 0;
        m_claim_id = 0;
    endfunction

    function automatic int pick(input int excl);
        for (int p = (1 << PrioW) - 1; p > int'(thr); p--)
            for (int i = 0; i < NumSrc; i++)
                if (m_st[i] == M_PEND && ie[i] && (i + 1) != excl && int'(prio[i*PrioW +: PrioW]) == p)
                    return i + 1;
        return 0;
    endfunction

    function automatic logic [NumSrc-1:0] model_ip();
        logic [NumSrc-1:0] v;
        v = '0;
        for (int i = 0; i < NumSrc; i++) v[i] = (m_st[i] == M_PEND);
        return v;
    endfunction

    function automatic void model_step();
        int claimed;
        int nxt;
        bit e;
        bit retrig;
        claimed = (claim_re && m_irq_id != 0 && m_st[m_irq_id-1] == M_PEND) ? m_irq_id : 0;
        nxt = pick(claimed);
        for (int i = 0; i < NumSrc; i++) begin
            e = intr_src[i] && !m_prev[i];
            case (m_st[i])
                M_IDLE: if (le[i] ? e : intr_src[i]) m_st[i] = M_PEND;
                M_PEND: if (i + 1 == claimed) m_st[i] = M_ACT;
                default: begin
                    if (complete_we && int'(complete_id) == i + 1) begin
                        retrig = le[i] ? (m_sticky[i] || e) : intr_src[i];
                        m_st[i] = retrig ? M_PEND : M_IDLE;
                        m_sticky[i] = 1'b0;
                    end else if (le[i] && e) begin
                        m_sticky[i] = 1'b1;
                    end
                end
            endcase
            m_prev[i] = intr_src[i];
        end
        if (claim_re) m_claim_id = m_irq_id;
        m_irq_id = nxt;
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        intr_src = '0;
        claim_re = 1'b0;
        complete_we = 1'b0;
        complete_id = '0;
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive(input logic [NumSrc-1:0] s, input bit c, input bit w, input int id);
        intr_src = s;
        claim_re = c;
        complete_we = w;
        complete_id = SrcW'(id);
        cycle();
        claim_re = 1'b0;
        complete_we = 1'b0;
        complete_id = '0;
    endtask

    task automatic check(input string nm, input logic [NumSrc-1:0] e_ip, input int e_irq,
                         input int e_id, input int e_cid);
        n_vec++;
        if (ip !== e_ip || irq !== (e_irq != 0) || irq_id !== SrcW'(e_id) || claim_id !== SrcW'(e_cid)) begin
            n_bad++;
            $display("FAIL %s: got ip=%h irq=%b id=%0d claim_id=%0d, want ip=%h irq=%0d id=%0d claim_id=%0d",
                     nm, ip, irq, irq_id, claim_id, e_ip, e_irq, e_id, e_cid);
        end else begin
            $display("[%s] ip=%h irq=%b id=%0d claim_id=%0d ok", nm, ip, irq, irq_id, claim_id);
        end
    endtask

    task automatic set_prio(input int idx, input int val);
        prio[idx*PrioW +: PrioW] = PrioW'(val);
    endtask

    typedef struct {
        logic [NumSrc-1:0] src;
        logic [NumSrc-1:0] ien;
        int                thr;
        int                claim;
        int                cwe;
        int                cid;
        logic [NumSrc-1:0] e_ip;
        int                e_irq;
        int                e_id;
        int                e_cid;
    } vec_t;

    vec_t tbl[26];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        int act_q[$];
        int cid;

        //            src          ie    thr clm cwe cid  e_ip        irq id cid
        tbl[0]  = '{32'h010, ALL, 0, 0, 0, 0, 32'h010, 0, 0, 0};
        tbl[1]  = '{32'h010, ALL, 0, 0, 0, 0, 32'h010, 1, 5, 0};
        tbl[2]  = '{32'h010, ALL, 0, 1, 0, 0, 32'h000, 0, 0, 5};
        tbl[3]  = '{32'h010, ALL, 0, 0, 0, 0, 32'h000, 0, 0, 5};
        tbl[4]  = '{32'h010, ALL, 0, 0, 1, 5, 32'h010, 0, 0, 5};
        tbl[5]  = '{32'h010, ALL, 0, 0, 0, 0, 32'h010, 1, 5, 5};
        tbl[6]  = '{32'h000, ALL, 0, 1, 0, 0, 32'h000, 0, 0, 5};
        tbl[7]  = '{32'h000, ALL, 0, 0, 1, 5, 32'h000, 0, 0, 5};
        tbl[8]  = '{32'h000, ALL, 0, 0, 0, 0, 32'h000, 0, 0, 5};
        tbl[9]  = '{32'h144, ALL, 0, 0, 0, 0, 32'h144, 0, 0, 5};
        tbl[10] = '{32'h144, ALL, 0, 0, 0, 0, 32'h144, 1, 7, 5};
        tbl[11] = '{32'h144, ALL, 0, 1, 0, 0, 32'h104, 1, 9, 7};
        tbl[12] = '{32'h144, ALL, 0, 1, 0, 0, 32'h004, 1, 3, 9};
        tbl[13] = '{32'h144, ALL, 0, 1, 0, 0, 32'h000, 0, 0, 3};
        tbl[14] = '{32'h144, ALL, 0, 0, 1, 7, 32'h040, 0, 0, 3};
        tbl[15] = '{32'h144, ALL, 0, 0, 1, 9, 32'h140, 1, 7, 3};
        tbl[16] = '{32'h000, ALL, 0, 0, 1, 3, 32'h140, 1, 7, 3};
        tbl[17] = '{32'h000, ALL, 0, 1, 0, 0, 32'h100, 1, 9, 7};
        tbl[18] = '{32'h000, ALL, 0, 1, 0, 0, 32'h000, 0, 0, 9};
        tbl[19] = '{32'h000, ALL, 0, 0, 1, 7, 32'h000, 0, 0, 9};
        tbl[20] = '{32'h000, ALL, 0, 0, 1, 9, 32'h000, 0, 0, 9};
        tbl[21] = '{32'h002, ALL, 4, 0, 0, 0, 32'h002, 0, 0, 9};
        tbl[22] = '{32'h002, ALL, 4, 0, 0, 0, 32'h002, 0, 0, 9};
        tbl[23] = '{32'h002, ALL, 3, 0, 0, 0, 32'h002, 1, 2, 9};
        tbl[24] = '{32'h402, ALL, 3, 0, 0, 0, 32'h402, 1, 2, 9};
        tbl[25] = '{32'h402, 32'hFFFF_FFFD, 0, 0, 0, 0, 32'h402, 0, 0, 9};

        set_prio(4, 3);
        set_prio(2, 2);
        set_prio(6, 5);
        set_prio(8, 5);
        set_prio(1, 4);
        set_prio(9, 1);
        set_prio(3, 6);
        set_prio(5, 7);
        ie = ALL;
        le = '0;
        model_reset();
        #3;
        check("reset", '0, 0, 0, 0);
        do_reset();

        for (int k = 0; k < 26; k++) begin
            thr = PrioW'(tbl[k].thr);
            ie = tbl[k].ien;
            drive(tbl[k].src, tbl[k].claim != 0, tbl[k].cwe != 0, tbl[k].cid);
            check($sformatf("tbl%0d", k), tbl[k].e_ip, tbl[k].e_irq, tbl[k].e_id, tbl[k].e_cid);
        end

        // Edge source 10: sticky edge while active, plain complete, edge coinciding with complete.
        ie = ALL;
        thr = '0;
        le = 32'h200;
        do_reset();
        drive(32'h200, 0, 0, 0);  check("edge_trig", 32'h200, 0, 0, 0);
        drive(32'h000, 0, 0, 0);  check("edge_irq", 32'h200, 1, 10, 0);
        drive(32'h000, 1, 0, 0);  check("edge_claim", 32'h0, 0, 0, 10);
        drive(32'h200, 0, 0, 0);  check("edge_sticky", 32'h0, 0, 0, 10);
        drive(32'h000, 0, 0, 0);  check("edge_hold", 32'h0, 0, 0, 10);
        drive(32'h000, 0, 1, 10); check("edge_cpl_sticky", 32'h200, 0, 0, 10);
        drive(32'h000, 0, 0, 0);  check("edge_irq2", 32'h200, 1, 10, 10);
        drive(32'h000, 1, 0, 0);  check("edge_claim2", 32'h0, 0, 0, 10);
        drive(32'h000, 0, 1, 10); check("edge_cpl_idle", 32'h0, 0, 0, 10);
        drive(32'h000, 0, 0, 0);  check("edge_idle", 32'h0, 0, 0, 10);
        drive(32'h200, 0, 0, 0);  check("edge_trig3", 32'h200, 0, 0, 10);
        drive(32'h000, 0, 0, 0);  check("edge_irq3", 32'h200, 1, 10, 10);
        drive(32'h000, 1, 0, 0);  check("edge_claim3", 32'h0, 0, 0, 10);
        drive(32'h200, 0, 1, 10); check("edge_cpl_same", 32'h200, 0, 0, 10);
        drive(32'h200, 0, 0, 0);  check("edge_irq4", 32'h200, 1, 10, 10);

        // Completes that must be ignored, then a claim with no irq.
        le = '0;
        do_reset();
        drive(32'h8, 0, 0, 0);  check("bogus_pend", 32'h8, 0, 0, 0);
        drive(32'h8, 0, 0, 0);  check("bogus_irq", 32'h8, 1, 4, 0);
        drive(32'h8, 0, 1, 0);  check("bogus_cpl0", 32'h8, 1, 4, 0);
        drive(32'h8, 0, 1, 33); check("bogus_cpl33", 32'h8, 1, 4, 0);
        drive(32'h8, 0, 1, 4);  check("bogus_cpl_pend", 32'h8, 1, 4, 0);
        thr = 3'd7;
        drive(32'h8, 0, 0, 0);  check("bogus_thr7", 32'h8, 0, 0, 0);
        drive(32'h8, 1, 0, 0);  check("bogus_claim0", 32'h8, 0, 0, 0);
        thr = '0;

        // Asynchronous reset in the middle of a cycle with source 6 active.
        do_reset();
        drive(32'h20, 0, 0, 0); check("rst_pend", 32'h20, 0, 0, 0);
        drive(32'h20, 0, 0, 0); check("rst_irq", 32'h20, 1, 6, 0);
        drive(32'h20, 1, 0, 0); check("rst_claim", 32'h0, 0, 0, 6);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", 32'h0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h20, 0, 0, 0); check("rst_rel1", 32'h20, 0, 0, 0);
        drive(32'h20, 0, 0, 0); check("rst_rel2", 32'h20, 1, 6, 0);

        // Random traffic with runtime reconfiguration and occasional resets.
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (n % 700 == 699) do_reset();
            if (n % 200 == 0) begin
                le = $urandom;
                ie = $urandom | $urandom;
                for (int i = 0; i < NumSrc; i++) set_prio(i, $urandom_range(0, 7));
                thr = PrioW'($urandom_range(0, 3));
            end
            act_q = {};
            for (int i = 0; i < NumSrc; i++) if (m_st[i] == M_ACT) act_q.push_back(i + 1);
            if (act_q.size() > 0 && $urandom_range(0, 9) < 7)
                cid = act_q[$urandom_range(0, act_q.size() - 1)];
            else
                cid = $urandom_range(0, 40);
            drive(intr_src ^ ($urandom & $urandom & $urandom), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, cid);
            check($sformatf("rand%0d", n), model_ip(), (m_irq_id != 0) ? 1 : 0, m_irq_id, m_claim_id);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
